// File: rtl/nibble_add_seq.sv
// Multi-nibble adder sequencer driving one shared 4-bit adder slice.
// Optional SKIP_ZERO_CARRY_EN bypasses the carry-in pass when carry is 0.
module nibble_add_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] op_a,
  input  logic [4*NIBBLES-1:0] op_b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] result,
  output logic                 cout_out,
  output logic [3:0]           add_a,
  output logic [3:0]           add_b,
  input  logic [3:0]           add_sum,
  input  logic                 add_cout
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ADD_AB  = 2'd1;
  localparam logic [1:0] ADD_CIN = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  result_q, result_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    tmp_q, tmp_d;
  logic          carry_q, carry_d;
  logic          c1_q, c1_d;
  logic          cout_q, cout_d;
  logic          last;

  assign last     = (idx_q == IW'(NIBBLES - 1));
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign result   = result_q;
  assign cout_out = cout_q;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    idx_d    = idx_q;
    tmp_d    = tmp_q;
    carry_d  = carry_q;
    c1_d     = c1_q;
    cout_d   = cout_q;
    add_a    = 4'h0;
    add_b    = 4'h0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = op_a;
          b_d     = op_b;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = ADD_AB;
        end
      end
      ADD_AB: begin
        add_a = a_q[4*idx_q +: 4];
        add_b = b_q[4*idx_q +: 4];
`ifdef SKIP_ZERO_CARRY_EN
        if (!carry_q) begin
          result_d[4*idx_q +: 4] = add_sum;
          carry_d = add_cout;
          if (last) begin
            cout_d  = add_cout;
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ADD_AB;
          end
        end else begin
          tmp_d   = add_sum;
          c1_d    = add_cout;
          state_d = ADD_CIN;
        end
`else
        tmp_d   = add_sum;
        c1_d    = add_cout;
        state_d = ADD_CIN;
`endif
      end
      ADD_CIN: begin
        add_a = tmp_q;
        add_b = {3'b000, carry_q};
        result_d[4*idx_q +: 4] = add_sum;
        // the two passes can never both carry, so OR is exact
        carry_d = c1_q | add_cout;
        if (last) begin
          cout_d  = c1_q | add_cout;
          state_d = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ADD_AB;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      tmp_q    <= '0;
      carry_q  <= 1'b0;
      c1_q     <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      tmp_q    <= tmp_d;
      carry_q  <= carry_d;
      c1_q     <= c1_d;
      cout_q   <= cout_d;
    end
  end

endmodule

// File: tb/tb_nibble_add_seq.sv
// Self-checking bench for nibble_add_seq with a behavioural adder slice.
module tb_nibble_add_seq;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, cout_out;
  logic [W-1:0] result;
  logic [3:0]   add_a, add_b, add_sum;
  logic         add_cout;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b};

  nibble_add_seq #(.NIBBLES(NIBBLES)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done),
    .result(result), .cout_out(cout_out),
    .add_a(add_a), .add_b(add_b),
    .add_sum(add_sum), .add_cout(add_cout)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Edges from acceptance until done is seen, derived from carry chain.
  function automatic int model_lat(input logic [W-1:0] a,
                                   input logic [W-1:0] b);
    int lat;
    logic [W:0] mask, part;
`ifdef SKIP_ZERO_CARRY_EN
    lat = NIBBLES;
    for (int i = 1; i < NIBBLES; i++) begin
      mask = ({{W{1'b0}}, 1'b1} << (4*i)) - 1'b1;
      part = ({1'b0, a} & mask) + ({1'b0, b} & mask);
      if (part[4*i]) lat++;
    end
`else
    mask = '0;
    part = {1'b0, a} + {1'b0, b};
    lat  = 2 * NIBBLES + int'(mask[0] & part[0]);
`endif
    return lat;
  endfunction

  task automatic run_op(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input string tag);
    logic [W:0] s;
    int lat;
    s = {1'b0, a} + {1'b0, b};
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    op_a  = W'($urandom);
    op_b  = W'($urandom);
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    while (!done && lat < 64) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, model_lat(a, b));
    chk({tag, "_res"}, result, s[W-1:0]);
    chk({tag, "_cout"}, cout_out, s[W]);
    @(posedge clk); #1;
    chk({tag, "_done_off"}, done, 0);
    chk({tag, "_idle"}, busy, 0);
    chk({tag, "_hold"}, result, s[W-1:0]);
  endtask

  initial begin
    int pulses;
    logic [W:0] s;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", result, 0);
    chk("rst_cout", cout_out, 0);
    chk("rst_adda", add_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_busy", busy, 0);
    chk("idle_addb", add_b, 0);

    run_op(16'h000A, 16'h0005, "small");
    run_op(16'hFFFF, 16'h0001, "ripple");
    run_op(16'hFFFF, 16'hFFFF, "allf");
    run_op(16'h1234, 16'h4321, "nocarry");
    run_op(16'h000F, 16'h0001, "onecarry");

    // second start mid-operation must be ignored
    s = {1'b0, 16'h1357} + {1'b0, 16'h2468};
    @(negedge clk);
    op_a = 16'h1357; op_b = 16'h2468; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    op_a = 16'h9999; op_b = 16'h7777; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("ign_pulses", pulses, 1);
    chk("ign_res", result, s[W-1:0]);
    chk("ign_cout", cout_out, s[W]);

    // reset during ADD_CIN of nibble 2
    @(negedge clk);
    op_a = 16'hFFFF; op_b = 16'hFFFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_res", result, 0);
    chk("abort_cout", cout_out, 0);
    chk("abort_add", {add_a, add_b}, 0);
    pulses = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    chk("abort_nodone", pulses, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h8001, 16'h7FFF, "post_rst");

    for (int i = 0; i < 20; i++)
      run_op(W'($urandom), W'($urandom), "rand");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/nibble_add_seq.md
Name: nibble_add_seq

Overview:
- Sequencer that performs a multi-nibble add by time-multiplexing one external 4-bit carry-less adder slice (a, b -> sum, cout).
- Operands are NIBBLES*4 bits wide, latched on start and processed LSB nibble first.
- Each nibble takes two adder passes: A+B, then +carry-in. The carry-out is the OR of the two passes' couts, which cannot both be 1.
- Sits between the register file/control path and the shared adder slice.

Parameters:
- NIBBLES, 4, number of 4-bit nibbles per operand (>=1); operand width W = 4*NIBBLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- op_a  in  W  operand A; latched when start is accepted.
- op_b  in  W  operand B; latched when start is accepted.
- busy  out  1  high from the cycle after start is accepted until DONE is left.
- done  out  1  one-cycle pulse; result and cout_out are valid.
- result  out  W  sum; holds until the next accepted start.
- cout_out  out  1  final carry; holds with result.
- add_a  out  4  to adder slice input a.
- add_b  out  4  to adder slice input b.
- add_sum  in  4  from adder slice sum (combinational in same cycle).
- add_cout  in  1  from adder slice cout.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, done, cout_out=0; result=0; add_a, add_b=0; internal idx, carry, tmp, c1 = 0.
- Reset mid-operation aborts immediately. No done is issued and result reads 0.
- States are IDLE, ADD_AB, ADD_CIN, DONE.
- IDLE:
  - add_a = add_b = 0.
  - If start=1: latch op_a/op_b, idx<=0, carry<=0, go to ADD_AB.
- ADD_AB:
  - add_a = a_reg[4*idx+:4], add_b = b_reg[4*idx+:4].
  - At the clock edge: tmp<=add_sum, c1<=add_cout, go to ADD_CIN.
- ADD_CIN:
  - add_a = tmp, add_b = {3'b000, carry}.
  - At the clock edge: result[4*idx+:4]<=add_sum, carry<=c1|add_cout.
  - If idx==NIBBLES-1: cout_out<=c1|add_cout, go to DONE.
  - Otherwise idx<=idx+1, go to ADD_AB.
- DONE:
  - done=1 for exactly this cycle; add_a/add_b = 0; return to IDLE.
  - busy=1 in DONE, 0 in IDLE.
- Latency: start is sampled at edge E0. done is high in the cycle following edge E0+2*NIBBLES, i.e. 9 clocks after acceptance for NIBBLES=4.
- result is modified nibble-by-nibble during the operation. It is only guaranteed valid when done=1 and thereafter.
- start while not in IDLE (ADD_AB/ADD_CIN/DONE) is ignored; it is not queued. Holding start high through DONE causes re-acceptance in the IDLE cycle after DONE (back-to-back throughput of 2*NIBBLES+2 cycles).
- op_a/op_b changes after acceptance have no effect.
- Wrap-around: the sum is modulo 2^W; the overflow bit appears only on cout_out.
- idx width is clog2(NIBBLES), minimum 1 bit.

Optional Feature:
- Macro SKIP_ZERO_CARRY_EN.
- Defined: in ADD_AB, if carry==0, write result[4*idx+:4]<=add_sum and carry<=add_cout directly, then advance idx (or go to DONE on the last nibble), skipping ADD_CIN.
  - Latency becomes NIBBLES + (number of nibbles entered with carry=1) cycles, then the DONE cycle.
  - Results are identical to the non-skip build.
- Not defined: every nibble always takes both passes; latency is fixed at 2*NIBBLES.

Test Plan (NIBBLES=4; the bench models the adder slice as {cout,sum}=a+b):
- Reset then idle: rst_n=0 for 3 cycles, release -> busy=0, done=0, result=16'h0000, cout_out=0, add_a=add_b=0.
- start with op_a=16'h000A, op_b=16'h0005 -> done pulse 9 cycles after acceptance, result=16'h000F, cout_out=0, busy=0 the following cycle.
- op_a=16'hFFFF, op_b=16'h0001 -> result=16'h0000, cout_out=1. Carry ripples through all nibbles via the ADD_CIN passes. op_a=op_b=16'hFFFF -> result=16'hFFFE, cout_out=1.
- Pulse start again 3 cycles into an operation with different operands -> ignored; first operation's result is unchanged and exactly one done pulse occurs.
- Drop rst_n during ADD_CIN of nibble 2 -> all outputs 0 asynchronously, no done pulse. A new start after release gives the correct result.
- With SKIP_ZERO_CARRY_EN: op_a=16'h1234, op_b=16'h4321 -> result=16'h5555, cout_out=0, done 5 cycles after acceptance. op_a=16'h000F, op_b=16'h0001 -> result=16'h0010, done 6 cycles after acceptance.
